cdc_reset_sequencer: RTL and testbench

- Ordered reset-release controller sitting downstream of cdc_reset_sync.
- Takes the synchronized reset and holds NUM_DOMAINS downstream reset outputs asserted for a minimum time.
- Releases the outputs one at a time, in index order, waiting for each domain's ready acknowledge (with timeout) before moving on.
- Also supports a software-requested full re-reset; reports completion and acknowledge timeouts.

---
 rtl/cdc_pkg.sv | 15 +
 rtl/cdc_seq_timer.sv | 24 ++
 rtl/cdc_reset_sequencer.sv | 128 ++++++++++++
 tb/tb_cdc_reset_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the ordered reset-release sequencer.
package cdc_pkg;

  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, GAP, DONE} seq_state_e;

  // Width needed to hold the largest terminal value any state compares against.
  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_seq_timer.sv
// Shared up-counter with clear and terminal-count compare against a per-state limit.
module cdc_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/cdc_reset_sequencer.sv
// Holds all downstream resets, then releases them one domain at a time,
// waiting for each domain's ready (with timeout) before moving on.
module cdc_reset_sequencer
  import cdc_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   all_ready,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [(NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1)-1:0] err_domain
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM0 = NUM_DOMAINS'(1);

  seq_state_e             state, state_next;
  logic [IDX_W-1:0]       idx, idx_next, err_next;
  logic [NUM_DOMAINS-1:0] rst_n_next;
  logic                   all_ready_next, tmo_next, ack;
  logic                   cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]       cnt_limit;

  // Mask-based select avoids a degenerate index when there is a single domain.
  assign ack  = |(dom_ready & (DOM0 << idx));
  assign busy = (state != DONE);

  cdc_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .limit(cnt_limit),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    rst_n_next     = dom_rst_n;
    all_ready_next = 1'b0;
    tmo_next       = timeout_err;
    err_next       = err_domain;
    cnt_en         = 1'b1;
    cnt_limit      = HOLD_LIM;

    case (state)
      HOLD: begin
        if (cnt_tc) begin
          rst_n_next[0] = 1'b1;
          idx_next      = '0;
          state_next    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_limit = ACK_LIM;
        // A late ack still advances; a missing one is logged and skipped.
        if (ack || cnt_tc) begin
          if (!ack) begin
            tmo_next = 1'b1;
            if (!timeout_err) err_next = idx;
          end
          if (idx == LAST_IDX) state_next = DONE;
          else state_next = (GAP_CYCLES == 0) ? RELEASE : GAP;
        end
      end
      GAP: begin
        cnt_limit = GAP_LIM;
        if (cnt_tc) state_next = RELEASE;
      end
      RELEASE: begin
        idx_next   = idx + IDX_W'(1);
        rst_n_next = dom_rst_n | (DOM0 << idx_next);
        state_next = WAIT_ACK;
      end
      DONE: begin
        cnt_en         = 1'b0;
        all_ready_next = &dom_ready;
      end
      default: state_next = HOLD;
    endcase

    // Software re-reset restarts the whole hold; error history is kept.
    if (sw_rst_req) begin
      state_next     = HOLD;
      idx_next       = '0;
      rst_n_next     = '0;
      all_ready_next = 1'b0;
      tmo_next       = timeout_err;
      err_next       = err_domain;
    end

    cnt_clr = srst || sw_rst_req || (state_next != state);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= HOLD;
      idx         <= '0;
      dom_rst_n   <= '0;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      err_domain  <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      dom_rst_n   <= rst_n_next;
      all_ready   <= all_ready_next;
      timeout_err <= tmo_next;
      err_domain  <= err_next;
    end
  end

endmodule

// File: tb/tb_cdc_reset_sequencer.sv
// Scoreboard bench: three sequencer builds, expected output transitions queued per build.
module tb_cdc_reset_sequencer;

  typedef struct packed {
    logic [3:0] rst;
    logic       ar;
    logic       busy;
    logic       tmo;
    logic [1:0] err;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  localparam int END_CYC = 400;
  localparam int BIG     = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, sw_a, sw_off;
  logic [3:0] mask_a;

  logic [3:0] rstn_a, rdy_a, d1_a = '0, d2_a = '0;
  logic       ar_a, busy_a, tmo_a;
  logic [1:0] err_a;
  logic [1:0] rstn_b, rdy_b, d1_b = '0, d2_b = '0;
  logic       ar_b, busy_b, tmo_b;
  logic [0:0] err_b;
  logic [0:0] rstn_c, rdy_c, d1_c = '0, d2_c = '0;
  logic       ar_c, busy_c, tmo_c;
  logic [0:0] err_c;

  // Each domain acknowledges two register stages after its reset releases,
  // so the ack is sampled on the third edge after release.
  always @(posedge clk) begin
    d1_a <= rstn_a; d2_a <= d1_a;
    d1_b <= rstn_b; d2_b <= d1_b;
    d1_c <= rstn_c; d2_c <= d1_c;
  end
  assign rdy_a = d2_a & mask_a;
  assign rdy_b = d2_b;
  assign rdy_c = d2_c;

  cdc_reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(16), .GAP_CYCLES(4), .ACK_TIMEOUT(64)) dut_a (
    .clk(clk), .srst(srst), .sw_rst_req(sw_a), .dom_ready(rdy_a), .dom_rst_n(rstn_a),
    .all_ready(ar_a), .busy(busy_a), .timeout_err(tmo_a), .err_domain(err_a));

  cdc_reset_sequencer #(.NUM_DOMAINS(2), .HOLD_CYCLES(16), .GAP_CYCLES(0), .ACK_TIMEOUT(3)) dut_b (
    .clk(clk), .srst(srst), .sw_rst_req(sw_off), .dom_ready(rdy_b), .dom_rst_n(rstn_b),
    .all_ready(ar_b), .busy(busy_b), .timeout_err(tmo_b), .err_domain(err_b));

  cdc_reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(16), .GAP_CYCLES(0), .ACK_TIMEOUT(3)) dut_c (
    .clk(clk), .srst(srst), .sw_rst_req(sw_off), .dom_ready(rdy_c), .dom_rst_n(rstn_c),
    .all_ready(ar_c), .busy(busy_c), .timeout_err(tmo_c), .err_domain(err_c));

  snap_t obs [3];
  assign obs[0] = {rstn_a, ar_a, busy_a, tmo_a, err_a};
  assign obs[1] = {2'b00, rstn_b, ar_b, busy_b, tmo_b, 1'b0, err_b};
  assign obs[2] = {3'b000, rstn_c, ar_c, busy_c, tmo_c, 1'b0, err_c};

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t  exq [3][$];
  snap_t prev [3];
  int    total = 0;
  int    passed = 0;
  bit    mon_done = 1'b0;

  task automatic push(input int inst, input int c, input snap_t s, input int lim);
    exp_t e;
    if (c < lim) begin
      e.cyc = c;
      e.s   = s;
      exq[inst].push_back(e);
    end
  endtask

  // Expected transitions of one full sequence whose hold count starts at edge e0.
  task automatic seq_expect(input int inst, input int n, input int gap, input int ackto,
                            input int e0, input int tdom, input int lim, input snap_t base);
    snap_t cur;
    int r;
    int a;
    cur = base;
    r   = e0 + 16;
    for (int i = 0; i < n; i++) begin
      cur.rst[i] = 1'b1;
      push(inst, r, cur, lim);
      if (i == tdom) begin
        a = r + ackto;
        if (!cur.tmo) cur.err = 2'(i);
        cur.tmo = 1'b1;
      end else begin
        a = r + 3;
      end
      if (i == n - 1) begin
        cur.busy = 1'b0;
        push(inst, a, cur, lim);
        if (tdom < 0) begin
          cur.ar = 1'b1;
          push(inst, a + 1, cur, lim);
        end
      end else begin
        if (i == tdom) push(inst, a, cur, lim);
        r = a + gap + 1;
      end
    end
  endtask

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: a due expectation is compared; any other output change is an error.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (exq[i].size() > 0 && exq[i][0].cyc == cyc) begin
          e = exq[i].pop_front();
          total++;
          if (obs[i] === e.s) passed++;
          else $display("FAIL event inst%0d cyc%0d got %b want %b", i, cyc, obs[i], e.s);
        end else if (obs[i] !== prev[i]) begin
          total++;
          $display("FAIL unexpected_change inst%0d cyc%0d got %b want %b", i, cyc, obs[i], prev[i]);
        end
        prev[i] = obs[i];
      end
      if (cyc == END_CYC) begin
        for (int i = 0; i < 3; i++) begin
          while (exq[i].size() > 0) begin
            e = exq[i].pop_front();
            total++;
            $display("FAIL missing inst%0d cyc%0d got none want %b", i, e.cyc, e.s);
          end
        end
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    snap_t rs;
    snap_t t;
    srst   = 1'b1;
    sw_a   = 1'b0;
    sw_off = 1'b0;
    mask_a = 4'hF;
    rs      = '0;
    rs.busy = 1'b1;
    for (int i = 0; i < 3; i++) push(i, 1, rs, BIG);

    // Power-up: first edge sampling srst low is edge 6.
    wait_neg(5);
    srst = 1'b0;
    seq_expect(0, 4, 4, 64, 6, -1, BIG, rs);
    seq_expect(1, 2, 0, 3, 6, -1, BIG, rs);
    seq_expect(2, 1, 0, 3, 6, -1, BIG, rs);

    // Ready drop after DONE lowers all_ready only.
    wait_neg(55);
    mask_a[1] = 1'b0;
    t = '0;
    t.rst = 4'hF;
    push(0, 56, t, BIG);
    wait_neg(58);
    mask_a = 4'hF;
    t.ar = 1'b1;
    push(0, 59, t, BIG);

    // Software re-reset from DONE.
    wait_neg(62);
    sw_a = 1'b1;
    push(0, 63, rs, BIG);
    wait_neg(63);
    sw_a = 1'b0;
    seq_expect(0, 4, 4, 64, 64, -1, BIG, rs);

    // Domain 2 never acknowledges.
    wait_neg(114);
    mask_a[2] = 1'b0;
    sw_a = 1'b1;
    push(0, 115, rs, BIG);
    wait_neg(115);
    sw_a = 1'b0;
    seq_expect(0, 4, 4, 64, 116, 2, BIG, rs);

    // Re-reset keeps the sticky error; second request lands in WAIT_ACK of domain 1.
    wait_neg(224);
    mask_a = 4'hF;
    sw_a = 1'b1;
    t = rs;
    t.tmo = 1'b1;
    t.err = 2'd2;
    push(0, 225, t, BIG);
    wait_neg(225);
    sw_a = 1'b0;
    seq_expect(0, 4, 4, 64, 226, -1, 252, t);
    wait_neg(251);
    sw_a = 1'b1;
    push(0, 252, t, BIG);
    wait_neg(252);
    sw_a = 1'b0;
    seq_expect(0, 4, 4, 64, 253, -1, BIG, t);

    // srst while in GAP after domain 1 clears everything, error included.
    wait_neg(304);
    sw_a = 1'b1;
    push(0, 305, t, BIG);
    wait_neg(305);
    sw_a = 1'b0;
    seq_expect(0, 4, 4, 64, 306, -1, 335, t);
    wait_neg(334);
    srst = 1'b1;
    for (int i = 0; i < 3; i++) push(i, 335, rs, BIG);
    wait_neg(337);
    srst = 1'b0;
    seq_expect(0, 4, 4, 64, 338, -1, BIG, rs);
    seq_expect(1, 2, 0, 3, 338, -1, BIG, rs);
    seq_expect(2, 1, 0, 3, 338, -1, BIG, rs);

    while (!mon_done) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
